// File: rtl/mdr_handshake.sv
// Memory data register: one word loaded from the datapath bus or from data memory,
// with a req/ack handshake to memory that aborts after TIMEOUT unacknowledged cycles.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transaction; bus loads and start pulses are accepted
// RD_WAIT | mem_req high for a read, waiting for mem_ack or timeout
// WR_WAIT | mem_req high for a write, waiting for mem_ack or timeout
module mdr_handshake #(
    parameter int DATA_WIDTH = 24,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic                  read_bus,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] Bus_out,
    input  logic                  mem_rd_start,
    input  logic                  mem_wr_start,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   data_reg, data_nxt;
    logic [7:0]              wait_cnt, wait_cnt_nxt;
    logic                    done_nxt;
    logic                    err_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            data_reg    <= '0;
            wait_cnt    <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            data_reg    <= data_nxt;
            wait_cnt    <= wait_cnt_nxt;
            done        <= done_nxt;
            timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        data_nxt     = data_reg;
        wait_cnt_nxt = wait_cnt;
        done_nxt     = 1'b0;
        err_nxt      = timeout_err;
        case (state)
            IDLE: begin
                if (write)
                    data_nxt = data_in;
                // write start has priority; a simultaneous read start is dropped
                if (mem_wr_start) begin
                    state_nxt    = WR_WAIT;
                    wait_cnt_nxt = '0;
                    err_nxt      = 1'b0;
                end else if (mem_rd_start) begin
                    state_nxt    = RD_WAIT;
                    wait_cnt_nxt = '0;
                    err_nxt      = 1'b0;
                end
            end
            RD_WAIT, WR_WAIT: begin
                // ack wins over a timeout landing in the same cycle
                if (mem_ack) begin
                    if (state == RD_WAIT)
                        data_nxt = mem_rdata;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                    if (wait_cnt + 8'd1 == TIMEOUT_CNT) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign mem_req   = busy;
    assign mem_we    = (state == WR_WAIT);
    assign mem_wdata = data_reg;
    assign Bus_out   = read_bus ? data_reg : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mdr_handshake.sv
// Bench for mdr_handshake: a transaction-level model checked every cycle plus
// directed scenarios with hand-computed literal expectations.
module tb_mdr_handshake;
    localparam int DW = 24;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          write, read_bus, mem_rd_start, mem_wr_start, mem_ack;
    logic [DW-1:0] data_in, mem_rdata;
    wire  [DW-1:0] Bus_out;
    logic [DW-1:0] mem_wdata;
    logic          mem_req, mem_we, busy, done, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    mdr_handshake #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .write(write), .read_bus(read_bus),
        .data_in(data_in), .Bus_out(Bus_out), .mem_rd_start(mem_rd_start),
        .mem_wr_start(mem_wr_start), .mem_req(mem_req), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an outstanding request ages one per unacked cycle.
    logic [DW-1:0] m_reg;
    logic          m_active, m_is_wr, m_done, m_err;
    int            m_age;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg = '0; m_active = 0; m_is_wr = 0; m_done = 0; m_err = 0; m_age = 0;
        end else if (m_active) begin
            m_done = 0;
            if (mem_ack) begin
                if (!m_is_wr) m_reg = mem_rdata;
                m_active = 0;
                m_done   = 1;
            end else begin
                m_age++;
                if (m_age >= TO) begin
                    m_active = 0;
                    m_err    = 1;
                end
            end
        end else begin
            m_done = 0;
            if (write) m_reg = data_in;
            if (mem_wr_start || mem_rd_start) begin
                m_active = 1;
                m_is_wr  = mem_wr_start;
                m_age    = 0;
                m_err    = 0;
            end
        end
    end

    int req_hi = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_active));
        check("mem_req", 32'(mem_req), 32'(m_active));
        if (m_active) check("mem_we", 32'(mem_we), 32'(m_is_wr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_reg));
        check("done", 32'(done), 32'(m_done));
        check("timeout_err", 32'(timeout_err), 32'(m_err));
        if (read_bus) check("Bus_out", 32'(Bus_out), 32'(m_reg));
        if (mem_req) req_hi++;
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        reset = 1; write = 0; read_bus = 1; mem_rd_start = 0; mem_wr_start = 0;
        mem_ack = 0; data_in = '0; mem_rdata = '0;
        tick(); tick();
        check("reset Bus_out", 32'(Bus_out), 32'h000000);
        check("reset busy", 32'(busy), 32'd0);
        reset = 0;
        tick();

        // bus load and drive
        write = 1; data_in = 24'hA5C3F0; tick(); write = 0;
        check("bus load", 32'(Bus_out), 32'hA5C3F0);

        // read: ack after 3 wait cycles
        req_hi = 0; done_cnt = 0;
        mem_rd_start = 1; tick(); mem_rd_start = 0;
        tick(); tick(); tick();
        mem_ack = 1; mem_rdata = 24'h123456; tick(); mem_ack = 0;
        check("rd done", 32'(done), 32'd1);
        tick();
        check("rd req cycles", 32'(req_hi), 32'd4);
        check("rd done count", 32'(done_cnt), 32'd1);
        check("rd reg", 32'(Bus_out), 32'h123456);
        check("rd busy after", 32'(busy), 32'd0);

        // write: ack on first req cycle
        write = 1; data_in = 24'h00FF00; tick(); write = 0;
        mem_wr_start = 1; tick(); mem_wr_start = 0;
        check("wr mem_we", 32'(mem_we), 32'd1);
        check("wr mem_wdata", 32'(mem_wdata), 32'h00FF00);
        mem_ack = 1; mem_rdata = 24'hDEAD00; tick(); mem_ack = 0;
        check("wr done", 32'(done), 32'd1);
        check("wr reg", 32'(Bus_out), 32'h00FF00);
        tick();

        // timeout
        req_hi = 0; done_cnt = 0;
        mem_rd_start = 1; tick(); mem_rd_start = 0;
        guard = 0;
        while (mem_req && guard < 40) begin tick(); guard++; end
        check("to bounded", 32'(guard < 40), 32'd1);
        tick();
        check("to req cycles", 32'(req_hi), 32'd15);
        check("to err", 32'(timeout_err), 32'd1);
        check("to no done", 32'(done_cnt), 32'd0);
        check("to reg", 32'(Bus_out), 32'h00FF00);
        mem_wr_start = 1; tick(); mem_wr_start = 0;
        check("to err cleared", 32'(timeout_err), 32'd0);
        mem_ack = 1; tick(); mem_ack = 0; tick();

        // both starts: write wins; starts and loads while busy are ignored
        mem_rd_start = 1; mem_wr_start = 1; tick(); mem_wr_start = 0;
        check("both mem_we", 32'(mem_we), 32'd1);
        write = 1; data_in = 24'hFFFFFF; tick(); write = 0; mem_rd_start = 0;
        check("busy load ignored", 32'(mem_wdata), 32'h00FF00);
        mem_ack = 1; mem_rdata = 24'h777777; tick(); mem_ack = 0;
        tick();
        check("busy start dropped", 32'(busy), 32'd0);
        check("conflict reg", 32'(Bus_out), 32'h00FF00);

        // ack coincident with the count reaching TIMEOUT
        mem_rd_start = 1; tick(); mem_rd_start = 0;
        repeat (14) tick();
        mem_ack = 1; mem_rdata = 24'hBEEF01; tick(); mem_ack = 0;
        check("edge done", 32'(done), 32'd1);
        check("edge err", 32'(timeout_err), 32'd0);
        check("edge reg", 32'(Bus_out), 32'hBEEF01);
        tick();

        // async reset mid-transaction
        done_cnt = 0;
        mem_rd_start = 1; tick(); mem_rd_start = 0;
        tick();
        #2 reset = 1;
        #1;
        check("arst mem_req", 32'(mem_req), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst reg", 32'(Bus_out), 32'h000000);
        tick(); reset = 0;
        tick(); tick(); tick();
        check("arst no done", 32'(done_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
